// File: rtl/imm_ext_pkg.sv
// Package shared by the immediate extender and its skid buffer.
//   MODE_*        : extension mode codes carried on in_mode
//   skid_state_e  : occupancy state of the 2-entry skid buffer
//   ext_imm()     : width-generic immediate extension. It works on a 64-bit
//                   container so one function serves every IN_W/OUT_W pair;
//                   callers cast the result down to OUT_W.
package imm_ext_pkg;

    localparam logic [1:0] MODE_SIGN   = 2'd0;
    localparam logic [1:0] MODE_ZERO   = 2'd1;
    localparam logic [1:0] MODE_UPPER  = 2'd2;
    localparam logic [1:0] MODE_BRANCH = 2'd3;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    function automatic logic [63:0] ext_imm(
        input logic [63:0] imm,
        input logic [1:0]  mode,
        input int unsigned in_w,
        input int unsigned out_w
    );
        logic [63:0] in_mask;
        logic [63:0] out_mask;
        logic [63:0] raw;
        logic [63:0] sext;
        logic [63:0] res;
        in_mask  = ~({64{1'b1}} << in_w);
        out_mask = ~({64{1'b1}} << out_w);
        raw      = imm & in_mask;
        // Sign bit fetched by shifting rather than a variable bit-select.
        sext     = (((raw >> (in_w - 1)) & 64'd1) != 64'd0) ? (raw | ~in_mask) : raw;
        case (mode)
            MODE_SIGN:  res = sext;
            MODE_ZERO:  res = raw;
            MODE_UPPER: res = raw << (out_w - in_w);
            default:    res = sext << 2;  // MODE_BRANCH: word offset to byte offset
        endcase
        return res & out_mask;
    endfunction

endpackage

// File: rtl/imm_ext_skid.sv
// Generic 2-entry valid/ready skid buffer.
// Ports:
//   clk, reset     : rising-edge clock, synchronous active-high reset
//   in_valid_i     : producer offers in_data_i
//   in_ready_o     : buffer can accept (registered, no path from out_ready_i)
//   in_data_i      : W-bit payload
//   out_ready_i    : consumer accepts out_data_o
//   out_data_o     : oldest buffered entry (main register)
//   state_o        : occupancy state; out_valid is state_o != SKID_EMPTY
//
// Handshake: a beat moves on an interface in a cycle where valid and ready
// are both high at the rising edge. A producer whose valid is high while
// ready is low must hold its payload unchanged; the buffer never drops,
// duplicates or reorders beats, and out_data_o is stable while unaccepted.
module imm_ext_skid
    import imm_ext_pkg::*;
#(
    parameter int W = 37
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [W-1:0] in_data_i,
    input  logic        out_ready_i,
    output logic [W-1:0] out_data_o,
    output skid_state_e state_o
);

    skid_state_e  state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_ready_q, in_ready_d;
    logic         accept;
    logic         xfer;

    assign accept = in_valid_i & in_ready_q;
    assign xfer   = (state_q != SKID_EMPTY) & out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    main_d  = in_data_i;
                    state_d = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (accept && xfer) begin
                    // Departing entry leaves main; the new one takes its place.
                    main_d = in_data_i;
                end else if (accept) begin
                    skid_d  = in_data_i;
                    state_d = SKID_TWO;
                end else if (xfer) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                // in_ready is low here, so only a transfer can happen.
                if (xfer) begin
                    main_d  = skid_q;
                    state_d = SKID_ONE;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
        // Ready is a registered look-ahead of the next occupancy.
        in_ready_d = (state_d != SKID_TWO);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SKID_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready_o = in_ready_q;
    assign out_data_o = main_q;
    assign state_o    = state_q;

endmodule

// File: rtl/imm_extend_unit.sv
// Pipelined immediate extender for the decode stage.
// The immediate is extended combinationally and registered on entry into a
// 2-entry skid buffer, giving 1-cycle latency and full throughput.
// Ports:
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake (in_ready registered)
//   in_imm [IN_W]        : raw immediate
//   in_mode [2]          : 0 sign, 1 zero, 2 upper (LUI), 3 branch offset
//   in_tag [TAG_W]       : sideband passed through with the result
//   out_valid/out_ready  : output handshake
//   out_data [OUT_W]     : extended result of the oldest entry
//   out_tag [TAG_W]      : tag of the result on out_data
module imm_extend_unit
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int W = OUT_W + TAG_W;

    logic [OUT_W-1:0] ext_data;
    logic [W-1:0]     skid_out;
    skid_state_e      skid_state;

    assign ext_data = OUT_W'(ext_imm(64'(in_imm), in_mode, IN_W, OUT_W));

    imm_ext_skid #(
        .W(W)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  ({in_tag, ext_data}),
        .out_ready_i(out_ready),
        .out_data_o (skid_out),
        .state_o    (skid_state)
    );

    assign out_valid = (skid_state != SKID_EMPTY);
    assign out_tag   = skid_out[W-1:OUT_W];
    assign out_data  = skid_out[OUT_W-1:0];

endmodule
